// File: rtl/wb_pc_unit.sv
// wb_pc_unit: writeback mux, branch/jump resolution and architectural PC.
// A taken redirect squashes the next FLUSH_CYCLES EX/WB slots, which are
// the wrong-path instructions already in flight behind the redirect.
module wb_pc_unit #(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] alu_in,
  input  logic [31:0] data_mem_in,
  input  logic [31:0] addr_in,
  input  logic [5:0]  rd_in,
  input  logic        n_in,
  input  logic        z_in,
  input  logic        reg_write_in,
  input  logic        memtoreg_in,
  input  logic        pctoreg_in,
  input  logic        branch_neg_in,
  input  logic        branch_z_in,
  input  logic        jump_in,
  input  logic        jump_mem_in,
  output logic        rf_we,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        redirect,
  output logic        flush,
  output logic        squashing
);

  // A zero-length squash still needs a legal one-bit counter.
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             taken;
  logic [31:0]      target;

  assign squashing = (state_q == SQUASH);
  assign pc        = pc_q;

  // Writeback port: pctoreg beats memtoreg beats the ALU result.
  always_comb begin
    rf_wdata = alu_in;
    if (pctoreg_in) begin
      rf_wdata = addr_in;
    end else if (memtoreg_in) begin
      rf_wdata = data_mem_in;
    end
    rf_we    = reg_write_in & ~squashing;
    rf_waddr = rd_in;
  end

  // Redirect resolution; wrong-path slots cannot redirect.
  always_comb begin
    taken    = jump_mem_in | jump_in | (branch_z_in & z_in) | (branch_neg_in & n_in);
    target   = jump_mem_in ? data_mem_in : addr_in;
    redirect = taken & ~squashing;
    flush    = redirect | squashing;
  end

  // Squash FSM next state: count down the wrong-path slots, ignoring stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (redirect && (FLUSH_CYCLES > 0)) begin
          state_d = SQUASH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      SQUASH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Next PC: redirect overrides stall; sequential step wraps at 2^32.
  always_comb begin
    pc_d = pc_q + 32'(PC_STEP);
    if (redirect) begin
      pc_d = target;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // State, counter and PC registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_wb_pc_unit.sv
// tb_wb_pc_unit: directed and random stimulus; a reference model pushes the
// expected outputs for each cycle into a queue and a monitor checks them.
module tb_wb_pc_unit;

  localparam int          FLUSH = 3;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] addr;
    logic [5:0]  rd;
    logic        n;
    logic        z;
    logic        rw;
    logic        mtr;
    logic        ptr;
    logic        bn;
    logic        bz;
    logic        j;
    logic        jm;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        redirect;
    logic        flush;
    logic        squashing;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] alu_in = '0, data_mem_in = '0, addr_in = '0;
  logic [5:0]  rd_in = '0;
  logic        n_in = 1'b0, z_in = 1'b0;
  logic        reg_write_in = 1'b0, memtoreg_in = 1'b0, pctoreg_in = 1'b0;
  logic        branch_neg_in = 1'b0, branch_z_in = 1'b0, jump_in = 1'b0, jump_mem_in = 1'b0;
  logic        rf_we, redirect, flush, squashing;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata, pc;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  bit stim_done = 1'b0;
  exp_t exp_q[$];

  // Reference model state: architectural PC and remaining wrong-path slots.
  logic [31:0] m_pc = RPC;
  int          m_left = 0;

  wb_pc_unit #(.FLUSH_CYCLES(FLUSH), .RESET_PC(RPC), .PC_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .alu_in(alu_in), .data_mem_in(data_mem_in), .addr_in(addr_in), .rd_in(rd_in),
    .n_in(n_in), .z_in(z_in),
    .reg_write_in(reg_write_in), .memtoreg_in(memtoreg_in), .pctoreg_in(pctoreg_in),
    .branch_neg_in(branch_neg_in), .branch_z_in(branch_z_in),
    .jump_in(jump_in), .jump_mem_in(jump_mem_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
    .redirect(redirect), .flush(flush), .squashing(squashing)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic bit is_taken(stim_t s);
    return s.jm || s.j || (s.bz && s.z) || (s.bn && s.n);
  endfunction

  // Expected outputs for this cycle from the written rules.
  function automatic exp_t model_out(stim_t s);
    exp_t e;
    bit   in_squash;
    in_squash   = (m_left > 0);
    e.squashing = in_squash;
    e.redirect  = is_taken(s) && !in_squash;
    e.flush     = e.redirect || in_squash;
    e.we        = s.rw && !in_squash;
    e.waddr     = s.rd;
    e.wdata     = s.ptr ? s.addr : (s.mtr ? s.dm : s.alu);
    e.pc        = m_pc;
    return e;
  endfunction

  // Model state advance at the clock edge.
  task automatic model_edge(stim_t s);
    bit          in_squash;
    bit          tk;
    logic [31:0] tgt;
    if (!s.rst_n) return;
    in_squash = (m_left > 0);
    tk        = is_taken(s) && !in_squash;
    tgt       = s.jm ? s.dm : s.addr;
    if (tk) m_pc = tgt;
    else if (!s.stall) m_pc = m_pc + 32'd1;
    if (tk) m_left = FLUSH;
    else if (in_squash) m_left = m_left - 1;
  endtask

  // One cycle: apply inputs, push expectation, advance model at the edge.
  task automatic step(stim_t s);
    rst_n = s.rst_n; stall = s.stall;
    alu_in = s.alu; data_mem_in = s.dm; addr_in = s.addr; rd_in = s.rd;
    n_in = s.n; z_in = s.z;
    reg_write_in = s.rw; memtoreg_in = s.mtr; pctoreg_in = s.ptr;
    branch_neg_in = s.bn; branch_z_in = s.bz; jump_in = s.j; jump_mem_in = s.jm;
    if (!s.rst_n) begin
      m_pc   = RPC;
      m_left = 0;
    end
    exp_q.push_back(model_out(s));
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL cyc %0d %s: got %h expected %h", cyc_no, nm, act, req);
    end
  endtask

  // Monitor: every cycle the outputs are valid; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we",     32'(rf_we),     32'(e.we));
        chk("rf_waddr",  32'(rf_waddr),  32'(e.waddr));
        chk("rf_wdata",  rf_wdata,       e.wdata);
        chk("redirect",  32'(redirect),  32'(e.redirect));
        chk("flush",     32'(flush),     32'(e.flush));
        chk("squashing", 32'(squashing), 32'(e.squashing));
        chk("pc",        pc,             e.pc);
        $display("cyc %0d pc=%h we=%b wdata=%h redir=%b flush=%b sq=%b",
                 cyc_no, pc, rf_we, rf_wdata, redirect, flush, squashing);
        cyc_no++;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    @(posedge clk); #1;

    // Reset: combinational writeback still follows reg_write_in.
    s = idle(); s.rst_n = 1'b0; s.rw = 1'b1; s.rd = 6'd7; s.alu = 32'h5;
    step(s); step(s);

    // Free-running PC, then a single stall.
    for (int i = 0; i < 6; i++) step(idle());
    s = idle(); s.stall = 1'b1; step(s);
    step(idle()); step(idle());

    // Writeback mux.
    s = idle(); s.alu = 32'h11; s.dm = 32'h22; s.addr = 32'h33; s.rd = 6'd5; s.rw = 1'b1;
    step(s);
    s.mtr = 1'b1; step(s);
    s.ptr = 1'b1; step(s);

    // Land at pc=0x10 then take a zero-flag branch to 0x40.
    s = idle(); s.j = 1'b1; s.addr = 32'h0D; step(s);
    for (int i = 0; i < 3; i++) step(idle());
    s = idle(); s.bz = 1'b1; s.z = 1'b1; s.addr = 32'h40; s.rw = 1'b1; s.rd = 6'd3; step(s);
    s = idle(); s.rw = 1'b1; s.rd = 6'd4;
    for (int i = 0; i < 4; i++) step(s);
    s = idle(); s.bz = 1'b1; s.z = 1'b0; s.addr = 32'h99; step(s);

    // Negative-flag branch taken and not taken.
    s = idle(); s.bn = 1'b1; s.n = 1'b1; s.addr = 32'h60; step(s);
    for (int i = 0; i < 4; i++) step(idle());
    s = idle(); s.bn = 1'b1; s.n = 1'b0; s.addr = 32'h99; step(s);

    // jump_mem beats jump; a jump in the second squash slot is ignored.
    s = idle(); s.j = 1'b1; s.jm = 1'b1; s.addr = 32'h40; s.dm = 32'h80; step(s);
    step(idle());
    s = idle(); s.j = 1'b1; s.addr = 32'h500; step(s);
    for (int i = 0; i < 3; i++) step(idle());

    // Redirect wins over stall; stall held through the squash.
    s = idle(); s.stall = 1'b1; s.j = 1'b1; s.addr = 32'h100; step(s);
    s = idle(); s.stall = 1'b1;
    for (int i = 0; i < 4; i++) step(s);
    step(idle());

    // PC wrap-around.
    s = idle(); s.j = 1'b1; s.addr = 32'hFFFF_FFFD; step(s);
    for (int i = 0; i < 5; i++) step(idle());

    // Reset in the second squash slot aborts the squash.
    s = idle(); s.j = 1'b1; s.addr = 32'h200; step(s);
    step(idle());
    s = idle(); s.rst_n = 1'b0; s.rw = 1'b1; step(s);
    s = idle(); s.rw = 1'b1; s.rd = 6'd9; step(s);
    step(idle()); step(idle());

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      s       = idle();
      s.rst_n = ($urandom_range(0, 49) != 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.alu   = $urandom();
      s.dm    = $urandom();
      s.addr  = $urandom();
      s.rd    = 6'($urandom());
      s.n     = 1'($urandom());
      s.z     = 1'($urandom());
      s.rw    = 1'($urandom());
      s.mtr   = 1'($urandom());
      s.ptr   = ($urandom_range(0, 3) == 0);
      s.bn    = ($urandom_range(0, 5) == 0);
      s.bz    = ($urandom_range(0, 5) == 0);
      s.j     = ($urandom_range(0, 9) == 0);
      s.jm    = ($urandom_range(0, 11) == 0);
      step(s);
    end
    step(idle());
    stim_done = 1'b1;
  end

  // End of run: every expectation must have been consumed.
  initial begin
    wait (stim_done);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
